dmem_unit: RTL



---
 rtl/dmem_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - MEM-stage data memory slave: RAM, MMIO window, sticky misalign flag
// Define DMEM_PERF_CNT_EN to add the load/store counters at MMIO +0x8/+0xC.
module dmem_unit #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  input  logic        rmem,
  input  logic        wmem,
  output logic [31:0] mem_rdata,
  output logic [31:0] tohost,
  output logic        halt,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_ram [DEPTH];

  logic                  w_mmio;
  logic                  w_misalign;
  logic                  w_store;
  logic                  w_load;
  logic                  w_ram_we;
  logic                  w_tohost_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;
  logic [31:0]           w_mmio_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  logic [31:0] r_rd_word;
  logic [1:0]  r_rd_off;
  logic [1:0]  r_rd_type;
  logic        r_rd_sign;
  logic [31:0] r_tohost;
  logic        r_halt;
  logic        r_err;
  logic [31:0] r_err_addr;
  logic [31:0] r_cycle;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_ld_cnt;
  logic [31:0] r_st_cnt;
`endif

  assign w_mmio = (mem_addr[31:12] == MMIO_BASE[31:12]);
  assign w_idx  = mem_addr[DEPTH_LOG2+1:2];

  always_comb begin
    w_misalign = 1'b0;
    case (mem_type)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = mem_addr[0];
      default: w_misalign = |mem_addr[1:0];
    endcase
    // The MMIO registers only understand whole-word accesses
    if (w_mmio && !mem_type[1]) w_misalign = 1'b1;
  end

  // A simultaneous load+store is a store; its load slot returns 0
  assign w_store     = wmem & ~w_misalign;
  assign w_load      = rmem & ~wmem & ~w_misalign;
  assign w_ram_we    = w_store & ~w_mmio;
  assign w_tohost_we = w_store & w_mmio & (mem_addr[11:0] == 12'h000);

  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = mem_wdata;
    case (mem_type)
      2'b00: begin
        w_be     = 4'b0001 << mem_addr[1:0];
        w_wlanes = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{mem_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = mem_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn && w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_ram[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_mmio_word = 32'h0;
    case (mem_addr[11:0])
      12'h000: w_mmio_word = r_tohost;
      12'h004: w_mmio_word = r_cycle;
`ifdef DMEM_PERF_CNT_EN
      12'h008: w_mmio_word = r_ld_cnt;
      12'h00C: w_mmio_word = r_st_cnt;
`endif
      default: w_mmio_word = 32'h0;
    endcase
  end

  // Rejected loads capture a zero word so the extractor yields 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_word <= 32'h0;
      r_rd_off  <= 2'b00;
      r_rd_type <= 2'b10;
      r_rd_sign <= 1'b0;
    end else if (rmem) begin
      if (w_load) begin
        r_rd_word <= w_mmio ? w_mmio_word : r_ram[w_idx];
        r_rd_off  <= mem_addr[1:0];
        r_rd_type <= mem_type;
        r_rd_sign <= mem_sign;
      end else begin
        r_rd_word <= 32'h0;
        r_rd_off  <= 2'b00;
        r_rd_type <= 2'b10;
        r_rd_sign <= 1'b0;
      end
    end
  end

  assign w_byte = r_rd_word[{r_rd_off, 3'b000} +: 8];
  assign w_half = r_rd_word[{r_rd_off[1], 4'b0000} +: 16];

  always_comb begin
    mem_rdata = r_rd_word;
    case (r_rd_type)
      2'b00:   mem_rdata = {{24{r_rd_sign & w_byte[7]}}, w_byte};
      2'b01:   mem_rdata = {{16{r_rd_sign & w_half[15]}}, w_half};
      default: mem_rdata = r_rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tohost   <= 32'h0;
      r_halt     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
      r_cycle    <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_tohost_we) begin
        r_tohost <= mem_wdata;
        r_halt   <= 1'b1;
      end
      if ((rmem || wmem) && w_misalign) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= mem_addr;
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ld_cnt <= 32'h0;
      r_st_cnt <= 32'h0;
    end else begin
      if (w_load)  r_ld_cnt <= r_ld_cnt + 32'd1;
      if (w_store) r_st_cnt <= r_st_cnt + 32'd1;
    end
  end
`endif

  assign tohost       = r_tohost;
  assign halt         = r_halt;
  assign misalign_err = r_err;
  assign err_addr     = r_err_addr;

endmodule
